// File: rtl/mul_job_sequencer.sv
// Command queue and launch/watchdog sequencer for the multiply top.
// Owns mem_mode/calc_init and returns one tagged completion record per job.
//
// state        | meaning
// -------------+---------------------------------------------------------
// S_IDLE       | waiting for a queued command; pops the FIFO head
// S_LAUNCH     | one cycle: mem_mode driven, calc_init pulsed
// S_WAIT_START | mem_mode held; waiting for mul_state to leave FREE
// S_RUN        | mem_mode held; waiting for mul_state to return to FREE
// S_REPORT     | completion record offered until done_ready

module mul_job_sequencer #(
    parameter int FIFO_DEPTH  = 4,
    parameter int TAG_W       = 4,
    parameter int START_WAIT  = 16,
    parameter int RUN_TIMEOUT = 200000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_mode,
    input  logic [TAG_W-1:0] cmd_tag,
    input  logic             abort,
    output logic [2:0]       mem_mode,
    output logic             calc_init,
    input  logic [3:0]       mul_state,
    output logic             done_valid,
    input  logic             done_ready,
    output logic [TAG_W-1:0] done_tag,
    output logic [1:0]       done_err,
    output logic             busy
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0]  FULL_CNT     = (AW+1)'(FIFO_DEPTH);
    localparam logic [31:0]  WAIT_LOAD    = 32'(START_WAIT - 1);
    localparam logic [31:0]  RUN_LOAD     = 32'(RUN_TIMEOUT - 1);
    localparam logic [1:0]   ERR_OK       = 2'd0;
    localparam logic [1:0]   ERR_ILLEGAL  = 2'd1;
    localparam logic [1:0]   ERR_START    = 2'd2;
    localparam logic [1:0]   ERR_RUN      = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT_START,
        S_RUN,
        S_REPORT
    } state_t;

    state_t           state, state_nxt;
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count;
    logic [2:0]       fifo_mode [FIFO_DEPTH];
    logic [TAG_W-1:0] fifo_tag  [FIFO_DEPTH];
    logic             push, pop;
    logic [2:0]       head_mode;
    logic             head_legal;
    logic [2:0]       job_mode;
    logic [TAG_W-1:0] job_tag;
    logic [1:0]       err_q, err_nxt;
    logic [31:0]      timer, timer_nxt;

    assign cmd_ready  = (count != FULL_CNT);
    assign push       = cmd_valid && cmd_ready;
    assign pop        = (state == S_IDLE) && (count != '0);
    assign head_mode  = fifo_mode[rd_ptr];
    assign head_legal = (head_mode >= 3'd1) && (head_mode <= 3'd4);

    // Storage needs no reset: entries are only read once count says they are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mode[wr_ptr] <= cmd_mode;
            fifo_tag[wr_ptr]  <= cmd_tag;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            job_mode <= '0;
            job_tag  <= '0;
            err_q    <= ERR_OK;
            timer    <= '0;
        end else begin
            state <= state_nxt;
            err_q <= err_nxt;
            timer <= timer_nxt;
            if (pop) begin
                job_mode <= head_mode;
                job_tag  <= fifo_tag[rd_ptr];
            end
        end
    end

    // Completion (mul_state back to FREE) is tested before abort and timeout in RUN.
    always_comb begin
        state_nxt = state;
        err_nxt   = err_q;
        timer_nxt = timer;
        case (state)
            S_IDLE: begin
                if (count != '0) begin
                    if (head_legal) begin
                        state_nxt = S_LAUNCH;
                        err_nxt   = ERR_OK;
                    end else begin
                        state_nxt = S_REPORT;
                        err_nxt   = ERR_ILLEGAL;
                    end
                end
            end
            S_LAUNCH: begin
                if (abort) begin
                    state_nxt = S_REPORT;
                    err_nxt   = ERR_RUN;
                end else begin
                    state_nxt = S_WAIT_START;
                    timer_nxt = WAIT_LOAD;
                end
            end
            S_WAIT_START: begin
                if (abort) begin
                    state_nxt = S_REPORT;
                    err_nxt   = ERR_RUN;
                end else if (mul_state != 4'd0) begin
                    state_nxt = S_RUN;
                    timer_nxt = RUN_LOAD;
                end else if (timer == '0) begin
                    state_nxt = S_REPORT;
                    err_nxt   = ERR_START;
                end else begin
                    timer_nxt = timer - 1'b1;
                end
            end
            S_RUN: begin
                if (mul_state == 4'd0) begin
                    state_nxt = S_REPORT;
                    err_nxt   = ERR_OK;
                end else if (abort || (timer == '0)) begin
                    state_nxt = S_REPORT;
                    err_nxt   = ERR_RUN;
                end else begin
                    timer_nxt = timer - 1'b1;
                end
            end
            S_REPORT: begin
                timer_nxt = '0;
                if (done_ready) state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Outputs decode registered state only, so reset clears mem_mode immediately.
    always_comb begin
        mem_mode   = 3'd0;
        calc_init  = 1'b0;
        done_valid = 1'b0;
        done_tag   = job_tag;
        done_err   = err_q;
        busy       = (state != S_IDLE) || (count != '0);
        case (state)
            S_LAUNCH: begin
                mem_mode  = job_mode;
                calc_init = 1'b1;
            end
            S_WAIT_START, S_RUN: begin
                mem_mode = job_mode;
            end
            S_REPORT: begin
                done_valid = 1'b1;
            end
            default: begin
                mem_mode = 3'd0;
            end
        endcase
    end

endmodule

// File: tb/tb_mul_job_sequencer.sv
// Directed bench for mul_job_sequencer; inputs driven and outputs sampled on the falling edge.
// RUN_TIMEOUT is shortened to 100 so the run watchdog can be exercised.

module tb_mul_job_sequencer;

    logic       clk;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_mode;
    logic [3:0] cmd_tag;
    logic       abort;
    logic [2:0] mem_mode;
    logic       calc_init;
    logic [3:0] mul_state;
    logic       done_valid;
    logic       done_ready;
    logic [3:0] done_tag;
    logic [1:0] done_err;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;
    int ci_cnt   = 0;
    int mm_cnt   = 0;
    int dv_cnt   = 0;

    mul_job_sequencer #(
        .FIFO_DEPTH (4),
        .TAG_W      (4),
        .START_WAIT (16),
        .RUN_TIMEOUT(100)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_mode  (cmd_mode),
        .cmd_tag   (cmd_tag),
        .abort     (abort),
        .mem_mode  (mem_mode),
        .calc_init (calc_init),
        .mul_state (mul_state),
        .done_valid(done_valid),
        .done_ready(done_ready),
        .done_tag  (done_tag),
        .done_err  (done_err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (calc_init === 1'b1)     ci_cnt <= ci_cnt + 1;
        if (mem_mode !== 3'd0)      mm_cnt <= mm_cnt + 1;
        if (done_valid === 1'b1)    dv_cnt <= dv_cnt + 1;
    end

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", name, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_cmd(input logic [2:0] m, input logic [3:0] t);
        int w;
        cmd_mode  = m;
        cmd_tag   = t;
        cmd_valid = 1'b1;
        w = 0;
        while (!cmd_ready && w < 100) begin
            step(1);
            w++;
        end
        check("push_ready", cmd_ready, 1);
        step(1);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_ci(output int n);
        n = 0;
        while (calc_init !== 1'b1 && n < 20) begin
            step(1);
            n++;
        end
        check("calc_init_seen", calc_init, 1);
    endtask

    task automatic wait_done(input logic [3:0] tag, input logic [1:0] err);
        int w;
        w = 0;
        while (done_valid !== 1'b1 && w < 300) begin
            step(1);
            w++;
        end
        check("done_seen", done_valid, 1);
        check("done_tag", done_tag, tag);
        check("done_err", done_err, err);
        check("report_mem_mode", mem_mode, 0);
        check("report_calc_init", calc_init, 0);
        done_ready = 1'b1;
        step(1);
        done_ready = 1'b0;
        check("done_drop", done_valid, 0);
    endtask

    initial begin
        int n;
        int k;
        int ci0;
        int mm0;
        int dv0;

        rst_n      = 1'b0;
        cmd_valid  = 1'b0;
        cmd_mode   = 3'd0;
        cmd_tag    = 4'd0;
        abort      = 1'b0;
        mul_state  = 4'd0;
        done_ready = 1'b0;
        step(2);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_mem_mode", mem_mode, 0);
        check("rst_calc_init", calc_init, 0);
        check("rst_done_valid", done_valid, 0);
        check("rst_done_tag", done_tag, 0);
        check("rst_done_err", done_err, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;
        step(2);

        // Normal job: AS, tag 5, mul_state busy for 40 cycles
        ci0 = ci_cnt;
        push_cmd(3'd1, 4'd5);
        wait_ci(n);
        check("launch_latency", n + 1, 2);
        check("launch_mem_mode", mem_mode, 1);
        step(3);
        check("wait_mem_mode", mem_mode, 1);
        mul_state = 4'd1;
        step(20);
        check("run_mem_mode", mem_mode, 1);
        check("run_no_done", done_valid, 0);
        step(20);
        mul_state = 4'd0;
        wait_done(4'd5, 2'd0);
        check("single_calc_init", ci_cnt - ci0, 1);

        // Five back-to-back commands against a stalled consumer; mul_state stays FREE
        ci0 = ci_cnt;
        for (int i = 0; i < 5; i++) push_cmd(3'd2, 4'(i));
        check("fifo_full_ready", cmd_ready, 0);
        check("fifo_full_busy", busy, 1);
        for (int i = 0; i < 5; i++) wait_done(4'(i), 2'd2);
        check("burst_calc_inits", ci_cnt - ci0, 5);
        check("burst_empty_ready", cmd_ready, 1);

        // Illegal modes never touch the multiply top
        ci0 = ci_cnt;
        mm0 = mm_cnt;
        push_cmd(3'd0, 4'd7);
        push_cmd(3'd6, 4'd8);
        wait_done(4'd7, 2'd1);
        wait_done(4'd8, 2'd1);
        check("illegal_calc_init", ci_cnt - ci0, 0);
        check("illegal_mem_mode", mm_cnt - mm0, 0);

        // Start timeout: report 17 cycles after calc_init (16 WAIT_START cycles)
        push_cmd(3'd2, 4'd9);
        wait_ci(n);
        k = 0;
        while (done_valid !== 1'b1 && k < 50) begin
            step(1);
            k++;
        end
        check("start_timeout_cycles", k, 17);
        wait_done(4'd9, 2'd2);

        // Abort ten cycles into RUN
        push_cmd(3'd3, 4'd10);
        wait_ci(n);
        step(2);
        mul_state = 4'd2;
        step(1);
        check("abort_run_mem_mode", mem_mode, 3);
        step(10);
        abort = 1'b1;
        step(1);
        abort     = 1'b0;
        mul_state = 4'd0;
        wait_done(4'd10, 2'd3);

        // Run timeout with stuck mul_state: 100 RUN cycles, report on the 101st edge
        push_cmd(3'd4, 4'd11);
        wait_ci(n);
        step(1);
        mul_state = 4'd3;
        k = 0;
        while (done_valid !== 1'b1 && k < 300) begin
            step(1);
            k++;
        end
        check("run_timeout_cycles", k, 101);
        mul_state = 4'd0;
        wait_done(4'd11, 2'd3);

        // Abort in the same cycle as completion: completion wins
        push_cmd(3'd1, 4'd12);
        wait_ci(n);
        step(1);
        mul_state = 4'd1;
        step(5);
        mul_state = 4'd0;
        abort     = 1'b1;
        step(1);
        abort = 1'b0;
        wait_done(4'd12, 2'd0);

        // Reset mid-RUN with two commands queued
        push_cmd(3'd1, 4'd13);
        wait_ci(n);
        step(1);
        mul_state = 4'd1;
        step(2);
        push_cmd(3'd2, 4'd14);
        push_cmd(3'd2, 4'd15);
        check("pre_reset_mem_mode", mem_mode, 1);
        check("pre_reset_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("async_rst_mem_mode", mem_mode, 0);
        check("async_rst_done_valid", done_valid, 0);
        check("async_rst_busy", busy, 0);
        mul_state = 4'd0;
        step(2);
        rst_n = 1'b1;
        ci0 = ci_cnt;
        mm0 = mm_cnt;
        dv0 = dv_cnt;
        step(30);
        check("post_rst_ready", cmd_ready, 1);
        check("post_rst_busy", busy, 0);
        check("post_rst_calc_init", ci_cnt - ci0, 0);
        check("post_rst_mem_mode", mm_cnt - mm0, 0);
        check("post_rst_done_valid", dv_cnt - dv0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
